// File: rtl/alu_pkg.sv
// Shared types for the ALU arbiter: opcodes, flag record and FSM states.
package alu_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_ORR = 2'b11
    } alu_op_t;

    // Bit order {N,Z,C,V}, N is the MSB when packed.
    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } arb_state_t;

    localparam nzcv_t NZCV_RESET = '0;

    // Gathers the four ALU flag wires into one record.
    function automatic nzcv_t pack_flags(input logic n, input logic z,
                                         input logic c, input logic v);
        nzcv_t f;
        f.n = n;
        f.z = z;
        f.c = c;
        f.v = v;
        return f;
    endfunction

endpackage

// File: rtl/alu_arbiter_rr.sv
// Round-robin arbiter: priority starts one past the last granted index and
// wraps. The pointer only moves when the owner signals an accepted grant.
module rr_arbiter #(
    parameter int NREQ = 2,
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] i_req,
    input  logic            i_advance,
    output logic [NREQ-1:0] o_grant,
    output logic [IW-1:0]   o_grant_idx
);

    logic [IW-1:0] r_last;
    logic [IW-1:0] w_cand;
    logic          w_found;

    // Last-grant pointer; reset to NREQ-1 so requester 0 has first priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= IW'(NREQ - 1);
        end else if (i_advance && (|i_req)) begin
            r_last <= o_grant_idx;
        end
    end

    // Scan from last+1 around the ring and take the first pending request.
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        w_cand      = '0;
        w_found     = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            w_cand = IW'((int'(r_last) + i) % NREQ);
            if (!w_found && i_req[w_cand]) begin
                w_found         = 1'b1;
                o_grant[w_cand] = 1'b1;
                o_grant_idx     = w_cand;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between NREQ requesters and owns the
// architectural NZCV register.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | waiting; grant one pending requester, latch its operands
//   ST_EXEC | latched operands drive the ALU; result captured at the edge
//   ST_RESP | result presented to the granted requester until it takes it
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int W    = 32,
    localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ-1:0][W-1:0] req_a,
    input  logic [NREQ-1:0][W-1:0] req_b,
    input  logic [NREQ-1:0][1:0]  req_op,
    input  logic [NREQ-1:0]       req_setflags,
    output logic [NREQ-1:0]       rsp_valid,
    input  logic [NREQ-1:0]       rsp_ready,
    output logic [W-1:0]          rsp_c,
    output logic [3:0]            rsp_nzcv,
    output logic [W-1:0]          alu_a,
    output logic [W-1:0]          alu_b,
    output logic [1:0]            alu_opcode,
    input  logic [W-1:0]          alu_c,
    input  logic                  alu_zero,
    input  logic                  alu_negative,
    input  logic                  alu_carry,
    input  logic                  alu_overflow,
    output logic [3:0]            nzcv,
    output logic                  busy
);

    arb_state_t    r_state;
    arb_state_t    w_state_nxt;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    alu_op_t       r_op;
    logic          r_sf;
    logic [IW-1:0] r_g;
    logic [W-1:0]  r_c;
    nzcv_t         r_rsp_flags;
    nzcv_t         r_nzcv;

    logic [NREQ-1:0] w_grant;
    logic [IW-1:0]   w_grant_idx;
    logic            w_accept;
    nzcv_t           w_alu_flags;

    assign w_alu_flags = pack_flags(alu_negative, alu_zero, alu_carry, alu_overflow);

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_req       (req_valid),
        .i_advance   (w_accept),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and handshake outputs; ready is only ever offered in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        req_ready   = '0;
        rsp_valid   = '0;
        busy        = 1'b1;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (|req_valid) begin
                    w_accept    = 1'b1;
                    req_ready   = w_grant;
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid[r_g] = 1'b1;
                if (rsp_ready[r_g]) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Latch the granted request; these registers also hold the ALU inputs steady.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a  <= '0;
            r_b  <= '0;
            r_op <= ALU_ADD;
            r_sf <= 1'b0;
            r_g  <= '0;
        end else if (w_accept) begin
            r_a  <= req_a[w_grant_idx];
            r_b  <= req_b[w_grant_idx];
            r_op <= alu_op_t'(req_op[w_grant_idx]);
            r_sf <= req_setflags[w_grant_idx];
            r_g  <= w_grant_idx;
        end
    end

    // Capture the ALU result at the end of EXEC; held until the next EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_c         <= '0;
            r_rsp_flags <= NZCV_RESET;
        end else if (r_state == ST_EXEC) begin
            r_c         <= alu_c;
            r_rsp_flags <= w_alu_flags;
        end
    end

    // Architectural flags take the ALU flags verbatim when the op asked for it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nzcv <= NZCV_RESET;
        end else if ((r_state == ST_EXEC) && r_sf) begin
            r_nzcv <= w_alu_flags;
        end
    end

    assign alu_a      = r_a;
    assign alu_b      = r_b;
    assign alu_opcode = r_op;
    assign rsp_c      = r_c;
    assign rsp_nzcv   = r_rsp_flags;
    assign nzcv       = r_nzcv;

endmodule
